serial_adder: RTL and testbench

//   Bit-serial WIDTH-bit adder for area-constrained datapaths.
//   - Bit cell: two half_adder instances plus an OR for the carry.
//   - A 1-bit carry register chains the cell across WIDTH clock cycles, LSB first.
//   - Operands are loaded in parallel on a start handshake; the result is presented
//     in parallel with a one-cycle done pulse.
//   - Sits upstream of any consumer that needs a registered sum without a WIDTH-wide

---
 rtl/serial_adder.sv | 106 ++++++++++
 tb/tb_serial_adder.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell plus a carry register, LSB first.
// Optional carry input port enabled by defining SERIAL_ADDER_CARRY_IN_EN.

module half_adder (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);
  assign s = x ^ y;
  assign c = x & y;
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_CARRY_IN_EN
  input  logic             carry_in,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [WIDTH-2:0] sum_sh;
  logic [WIDTH-1:0] sum_nx;
  logic [CW-1:0]    cnt;
  logic             c, cnx, cin;
  logic             s1, c1, bs, c2;
  logic             ld, last;

`ifdef SERIAL_ADDER_CARRY_IN_EN
  assign cin = carry_in;
`else
  assign cin = 1'b0;
`endif

  // Bit cell: two half adders, OR of the partial carries gives majority.
  half_adder u_ha0 (.x(a_sh[0]), .y(b_sh[0]), .s(s1), .c(c1));
  half_adder u_ha1 (.x(s1),      .y(c),       .s(bs), .c(c2));
  assign cnx    = c1 | c2;
  assign sum_nx = {bs, sum_sh};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    ld       = 1'b0;
    last     = (cnt == CW'(WIDTH - 1));
    case (state)
      IDLE: if (start) begin ld = 1'b1; state_nx = ADD; end
      ADD:  if (last) state_nx = DONE;
      DONE: begin
        if (start) begin ld = 1'b1; state_nx = ADD; end
        else state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh      <= '0;
      b_sh      <= '0;
      sum_sh    <= '0;
      c         <= 1'b0;
      cnt       <= '0;
      sum       <= '0;
      carry_out <= 1'b0;
    end else if (ld) begin
      a_sh   <= a;
      b_sh   <= b;
      sum_sh <= '0;
      c      <= cin;
      cnt    <= '0;
    end else if (state == ADD) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      sum_sh <= sum_nx[WIDTH-1:1];
      c      <= cnx;
      cnt    <= cnt + 1'b1;
      // Result registers only move on the final bit; partials stay internal.
      if (last) begin
        sum       <= sum_nx;
        carry_out <= cnx;
      end
    end
  end

  assign busy = (state == ADD);
  assign done = (state == DONE);
endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: vector table, hand sequences, random sweep.
module tb_serial_adder;
  localparam int W = 8;
  localparam time P = 10;

  logic         clk = 0, rst = 1, start = 0;
  logic [W-1:0] a = '0, b = '0, sum;
  logic         busy, done, carry_out;
  logic         cin_drv = 0;

  typedef struct {
    logic [W-1:0] a, b;
    logic         cin;
    logic [W-1:0] es;
    logic         ec;
  } vec_t;

  vec_t             tbl[$];
  logic [W:0]       exp_q[$];
  logic [W:0]       last_exp = '0;
  int               checks = 0, failures = 0;
  int               cyc = 0, ndone = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
`ifdef SERIAL_ADDER_CARRY_IN_EN
    .carry_in(cin_drv),
`endif
    .busy(busy), .done(done), .sum(sum), .carry_out(carry_out)
  );

  always #(P/2) clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      ndone++;
      if (exp_q.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        last_exp = exp_q.pop_front();
        chk("result", {carry_out, sum}, last_exp);
      end
    end
  end

  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
`ifdef SERIAL_ADDER_CARRY_IN_EN
    return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
`else
    return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, 1'b0 & ci};
`endif
  endfunction

  // One operation from IDLE; optional ignored start pulse during ADD.
  task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                       input logic [W:0] e, input bit midpulse);
    int bad;
    @(posedge clk); #1;
    a = x; b = y; cin_drv = ci; start = 1;
    @(posedge clk); #1;
    exp_q.push_back(e);
    start = 0;
    a = ~x; b = ~y; cin_drv = ~ci;
    bad = 0;
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      if (busy !== 1'b1 || done !== 1'b0) bad++;
      if (midpulse && i == 3) begin #1 start = 1; a = 8'h11; b = 8'h22; end
      if (midpulse && i == 4) begin #1 start = 0; end
    end
    chk("busy_window", bad, 0);
    @(negedge clk);
    chk("done_at_W", {busy, done}, 2'b01);
    @(negedge clk);
    chk("done_falls", done, 0);
    chk("held", {carry_out, sum}, e);
  endtask

  initial begin
    int b2b_last, n;
    logic [W-1:0] rx, ry;
    logic         rc;
    logic [W:0]   pend;
    #(1000000);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] rx, ry;
    logic         rc;
    int           t0, n, d0;
    tbl.push_back('{8'h35, 8'h4A, 0, 8'h7F, 0});
    tbl.push_back('{8'hFF, 8'h01, 0, 8'h00, 1});
    tbl.push_back('{8'h80, 8'h80, 0, 8'h00, 1});
    tbl.push_back('{8'h0F, 8'h01, 0, 8'h10, 0});
    tbl.push_back('{8'hAA, 8'h55, 0, 8'hFF, 0});
    tbl.push_back('{8'hFF, 8'hFF, 0, 8'hFE, 1});
    tbl.push_back('{8'h12, 8'h34, 0, 8'h46, 0});
    tbl.push_back('{8'h00, 8'h00, 0, 8'h00, 0});
`ifdef SERIAL_ADDER_CARRY_IN_EN
    tbl.push_back('{8'hFF, 8'h00, 1, 8'h00, 1});
    tbl.push_back('{8'hFF, 8'h00, 0, 8'hFF, 0});
    tbl.push_back('{8'h7F, 8'h00, 1, 8'h80, 0});
`endif

    // Reset and idle quiet period.
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_state", {busy, done, carry_out, sum}, 0);
    d0 = ndone;
    repeat (20) @(negedge clk);
    chk("idle_no_done", ndone - d0, 0);

    foreach (tbl[i])
      do_op(tbl[i].a, tbl[i].b, tbl[i].cin, {tbl[i].ec, tbl[i].es}, 0);

    // Mid-ADD start pulse must not disturb the in-flight result.
    do_op(8'h35, 8'h4A, 0, {1'b0, 8'h7F}, 1);
    repeat (12) @(negedge clk);
    chk("no_extra_done", exp_q.size(), 0);

    // Back-to-back: start held high, new operands presented during each ADD.
    @(posedge clk); #1;
    rx = 8'h01; ry = 8'h02; a = rx; b = ry; cin_drv = 0; start = 1;
    t0 = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      exp_q.push_back(model(rx, ry, 1'b0));
      rx = rx * 8'd37 + 8'd91; ry = ry * 8'd13 + 8'd200;
      a = rx; b = ry;
      if (i == 3) start = 0;
      n = 0;
      do begin @(negedge clk); n++; end while (!done && n < 30);
      chk("b2b_done_seen", done, 1);
      if (i > 0) chk("b2b_period", cyc - t0, 9);
      t0 = cyc;
    end
    @(negedge clk);
    chk("b2b_done_falls", done, 0);

    // Reset mid-ADD discards the operation.
    @(posedge clk); #1;
    a = 8'hAA; b = 8'h55; start = 1;
    @(posedge clk); #1 start = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("rst_mid_add", {busy, done, carry_out, sum}, 0);
    d0 = ndone;
    repeat (12) @(negedge clk);
    chk("rst_no_done", ndone - d0, 0);
    do_op(8'h0F, 8'h01, 0, {1'b0, 8'h10}, 0);

    // Random sweep against the arithmetic model.
    for (int i = 0; i < 500; i++) begin
      rx = W'($urandom); ry = W'($urandom); rc = 1'($urandom);
      do_op(rx, ry, rc, model(rx, ry, rc), 0);
    end

    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
